sram_ctrl: RTL and testbench

Parametrised single-port synchronous SRAM controller with a valid/ready request interface, registered read data, and a hardware clear sequence after reset. It replaces direct `re`/`we` strobing of the memory array with a handshake-driven front end. It sits between a requesting master (CPU datapath or test sequencer) and the on-chip storage array it instantiates.

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_ctrl_if.sv | 36 +++
 rtl/sram_ctrl_mem.sv | 46 ++++
 rtl/sram_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types, default sizes and the parity helper for the
// SRAM controller. Optional parity storage is enabled by SRAM_CTRL_PARITY_EN.
package sram_ctrl_pkg;

    localparam int DEF_AW   = 10;
    localparam int DEF_DW   = 12;
    // Widest data word the parity helper handles; narrower words are
    // zero-extended, which leaves the XOR unchanged.
    localparam int PAR_MAXW = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [PAR_MAXW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/response bundle between a master and sram_ctrl.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_we/req_addr/req_wdata/err_inject are only
// meaningful while req_valid is high. req_ready never depends on req_valid.
// Responses have no ready: rsp_valid is a one-cycle pulse per accepted read
// and the master must take rsp_rdata/rsp_err in that cycle.
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          err_inject;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, err_inject,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, err_inject,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/sram_ctrl_mem.sv
// sram_ctrl_mem: 2^AW x MW single-port synchronous array with a registered
// read port. Pure storage; all arbitration lives in sram_ctrl.
module sram_ctrl_mem #(
    parameter int AW = 10,
    parameter int MW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [MW-1:0] wdata,
    output logic [MW-1:0] rdata
);

    logic [MW-1:0] mem_q [2**AW];
    logic [MW-1:0] rdata_q;
    logic [MW-1:0] rdata_d;

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register holds its value between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Read data register, cleared so the bus reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end for a single-port SRAM. After reset it
// walks every address writing CLR_VAL (busy high), then serves one request
// per cycle with one-cycle read latency.
// Optional feature macro: SRAM_CTRL_PARITY_EN (stores an even-parity bit per
// word and flags mismatches on rsp_err).
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int            AW      = DEF_AW,
    parameter int            DW      = DEF_DW,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus,
    output state_t      dbg_state
);

`ifdef SRAM_CTRL_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    state_t        state_q, state_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic          rsp_valid_q, rsp_valid_d;

    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] mem_rdata;

    logic [MW-1:0] req_word;
    logic [MW-1:0] clr_word;

`ifdef SRAM_CTRL_PARITY_EN
    // Stored parity is deliberately flipped when err_inject is set.
    assign req_word = {even_parity(PAR_MAXW'(bus.req_wdata)) ^ bus.err_inject,
                       bus.req_wdata};
    assign clr_word = {even_parity(PAR_MAXW'(CLR_VAL)), CLR_VAL};
`else
    logic unused_err_inject;
    assign unused_err_inject = bus.err_inject;
    assign req_word = bus.req_wdata;
    assign clr_word = CLR_VAL;
`endif

    // Next-state logic: clear sweep in CLEAR, request muxing in RUN.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = bus.req_addr;
        mem_wdata   = req_word;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q[AW-1:0];
                mem_wdata = clr_word;
                clr_cnt_d = clr_cnt_q + 1'b1;
                // Bit AW sets exactly when the last address has been written.
                if (clr_cnt_d[AW]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        mem_we = 1'b1;
                    end else begin
                        mem_re      = 1'b1;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        // Nothing touches the array on a reset edge; the clear sweep restarts.
        if (rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    // State, clear counter and response-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    sram_ctrl_mem #(
        .AW (AW),
        .MW (MW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign bus.req_ready = (state_q == RUN);
    assign bus.busy      = (state_q == CLEAR);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = mem_rdata[DW-1:0];
`ifdef SRAM_CTRL_PARITY_EN
    assign bus.rsp_err   = rsp_valid_q &&
                           (even_parity(PAR_MAXW'(mem_rdata[DW-1:0])) != mem_rdata[DW]);
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed, table-driven bench for sram_ctrl (AW=10, DW=12).
// Build with SRAM_CTRL_PARITY_EN defined to exercise the parity rows.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int AW = 10;
    localparam int DW = 12;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    sram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sram_ctrl #(.AW(AW), .DW(DW), .CLR_VAL('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          inj;
        logic          exp_valid;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

`ifdef SRAM_CTRL_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_wr(input int a, input int d, input logic inj);
        vecs.push_back('{1'b1, AW'(a), DW'(d), inj, 1'b0, '0, 1'b0});
    endtask

    task automatic add_rd(input int a, input int d, input logic e);
        vecs.push_back('{1'b0, AW'(a), '0, 1'b0, 1'b1, DW'(d), e});
    endtask

    // Drive a request for one cycle starting at the next falling edge.
    task automatic drive(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic inj);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.err_inject = inj;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.err_inject = 1'b0;
    endtask

    // Count edges from reset release until req_ready, while a write (5,7)
    // is held on the bus; it must never be accepted.
    task automatic wait_clear(input string tag);
        int  edges;
        logic ok;
        edges = 0;
        ok    = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = AW'(5);
        bus.req_wdata  = DW'(7);
        bus.err_inject = 1'b0;
        while (edges < 2000) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.req_ready) break;
            if (!bus.busy || bus.rsp_valid) ok = 1'b0;
        end
        bus.req_valid = 1'b0;
        chk({tag, "_clear_edges"}, edges, 1024);
        chk({tag, "_busy_during_clear"}, {31'd0, ok}, 1);
        chk({tag, "_busy_after"}, {31'd0, bus.busy}, 0);
        chk({tag, "_state_run"}, {31'd0, dbg_state}, {31'd0, RUN});
    endtask

    // Read one address and check the response one cycle after acceptance.
    task automatic read_chk(input string name, input int a, input int d);
        drive(1'b0, AW'(a), '0, 1'b0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, {31'd0, bus.rsp_valid}, 1);
        chk({name, "_rdata"}, {20'd0, bus.rsp_rdata}, d);
        idle();
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.err_inject = 1'b0;

        // Directed vector table; reads are back-to-back with the writes.
        add_wr(12, 99, 0);
        add_wr(24, 198, 0);
        add_wr(1023, 4095, 0);
        add_rd(12, 99, 0);
        add_rd(24, 198, 0);
        add_rd(1023, 4095, 0);
        add_wr(36, 297, 0);
        add_rd(36, 297, 0);
        add_rd(36, 297, 0);
        add_rd(5, 0, 0);
        add_rd(500, 0, 0);
        add_rd(0, 0, 0);
        add_wr(60, 495, 1);
        add_rd(60, 495, PAR_ON);
        add_wr(72, 1234, 0);
        add_rd(72, 1234, 0);

        // Reset values while rst is held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        chk("rst_rsp_rdata", {20'd0, bus.rsp_rdata}, 0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 0);
        chk("rst_state", {31'd0, dbg_state}, {31'd0, CLEAR});

        wait_clear("init");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].inj);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.rsp_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_rdata", i), {20'd0, bus.rsp_rdata}, {20'd0, vecs[i].exp_rdata});
                chk($sformatf("vec%0d_err", i), {31'd0, bus.rsp_err}, {31'd0, vecs[i].exp_err});
            end
        end
        idle();
        @(posedge clk);
        #1;
        chk("pulse_drops", {31'd0, bus.rsp_valid}, 0);

        // Reset asserted on the cycle a read is accepted: no response.
        drive(1'b0, AW'(12), '0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        chk("midrst_busy", {31'd0, bus.busy}, 1);
        chk("midrst_ready", {31'd0, bus.req_ready}, 0);
        wait_clear("re");
        read_chk("reclr_12", 12, 0);
        read_chk("reclr_1023", 1023, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
